// File: rtl/isq_pkg.sv
// rtl/isq_pkg.sv - shared sizing and bit-vector helpers for the issue queue scheduler
package isq_pkg;

    localparam int ISQ_DEPTH = 8;
    localparam int ISQ_IDX_W = $clog2(ISQ_DEPTH);

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [4:0] isq_ffs(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] isq_oh_to_idx(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/isq_age_matrix.sv
// rtl/isq_age_matrix.sv - relative-age flops and oldest-ready grant for the issue queue
module isq_age_matrix
    import isq_pkg::*;
#(
    parameter int DEPTH = ISQ_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] free_oh,
    input  logic [DEPTH-1:0] occupied,
    input  logic [DEPTH-1:0] rdy,
    output logic [DEPTH-1:0] grant
);

    // age[i][j] set means slot i entered the queue before slot j
    logic [DEPTH-1:0][DEPTH-1:0] age;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            age <= '0;
        end else if (flush) begin
            age <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (free_oh[i] || free_oh[j]) begin
                        age[i][j] <= 1'b0;
                    end else if (alloc_oh[i]) begin
                        age[i][j] <= 1'b0;
                    end else if (alloc_oh[j]) begin
                        age[i][j] <= occupied[i];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_pick
        logic [DEPTH-1:0] older;
        for (genvar j = 0; j < DEPTH; j++) begin : g_col
            assign older[j] = age[j][i];
        end
        assign grant[i] = rdy[i] & ~|(rdy & older);
    end

endmodule

// File: rtl/isq_sched_ctrl.sv
// rtl/isq_sched_ctrl.sv - slot allocation, oldest-first issue select and occupancy for one issue queue
module isq_sched_ctrl
    import isq_pkg::*;
#(
    parameter int DEPTH = ISQ_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic [IDX_W-1:0] enq_idx,
    output logic [DEPTH-1:0] entry_wr_en,
    output logic [DEPTH-1:0] entry_clear,
    input  logic [DEPTH-1:0] entry_valid,
    input  logic [DEPTH-1:0] entry_rdy,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [IDX_W-1:0] issue_idx,
    output logic [IDX_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] pending_wr;
    logic [DEPTH-1:0] occupied;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] issue_oh;
    logic [DEPTH-1:0] grant;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W-1:0] locked_idx;
    logic             lock;
    logic             enq_fire;
    logic             issue_fire;

    // A slot written last cycle has not raised valid_out yet, so it is still treated as taken.
    assign occupied  = entry_valid | pending_wr;
    assign free_vec  = ~occupied;
    assign enq_ready = (|free_vec) & ~flush;
    assign enq_idx   = IDX_W'(isq_ffs(32'(free_vec)));
    assign enq_fire  = enq_valid & enq_ready;
    assign alloc_oh  = enq_fire ? (DEPTH'(1) << enq_idx) : '0;
    assign entry_wr_en = alloc_oh;

    isq_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .alloc_oh (alloc_oh),
        .free_oh  (issue_oh),
        .occupied (occupied),
        .rdy      (entry_rdy),
        .grant    (grant)
    );

    // Once offered, the slot is held until accepted so the issue port sees a stable index.
    assign cand_idx    = IDX_W'(isq_oh_to_idx(32'(grant)));
    assign issue_valid = ~flush & (lock | (|grant));
    assign issue_idx   = lock ? locked_idx : cand_idx;
    assign issue_fire  = issue_valid & issue_ready;
    assign issue_oh    = issue_fire ? (DEPTH'(1) << issue_idx) : '0;
    assign entry_clear = flush ? '1 : issue_oh;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_wr <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            count      <= '0;
        end else if (flush) begin
            pending_wr <= '0;
            lock       <= 1'b0;
            count      <= '0;
        end else begin
            pending_wr <= alloc_oh;
            if (issue_fire) begin
                lock <= 1'b0;
            end else if (issue_valid) begin
                lock       <= 1'b1;
                locked_idx <= issue_idx;
            end
            case ({enq_fire, issue_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    a_no_enq_when_full: assert property (@(posedge clock) disable iff (!reset_n) !(enq_fire && full));
    a_no_issue_when_empty: assert property (@(posedge clock) disable iff (!reset_n) !(issue_fire && empty));

endmodule

// File: tb/tb_isq_sched_ctrl.sv
// tb/tb_isq_sched_ctrl.sv - self-checking bench for isq_sched_ctrl with an in-order queue model
module tb_isq_sched_ctrl;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             enq_valid = 1'b0;
    logic             issue_ready = 1'b0;
    logic             enq_ready;
    logic [IDX_W-1:0] enq_idx;
    logic [IDX_W-1:0] issue_idx;
    logic [DEPTH-1:0] entry_wr_en;
    logic [DEPTH-1:0] entry_clear;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_rdy;
    logic [DEPTH-1:0] want_rdy = '0;
    logic             issue_valid;
    logic [IDX_W:0]   count;
    logic             full;
    logic             empty;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    isq_sched_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_idx     (enq_idx),
        .entry_wr_en (entry_wr_en),
        .entry_clear (entry_clear),
        .entry_valid (entry_valid),
        .entry_rdy   (entry_rdy),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_idx   (issue_idx),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    // Queue slots: valid_out rises the edge after the write strobe, ready follows valid.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) entry_valid <= '0;
        else          entry_valid <= (entry_valid & ~entry_clear) | entry_wr_en;
    end
    assign entry_rdy = entry_valid & want_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: slot indices kept in arrival order, oldest first.
    int m_q[$];
    bit m_lock;
    int m_lidx;
    bit s_flush, s_ef, s_if, s_lk;
    int s_ei, s_ii;

    always @(negedge clock) begin
        logic [7:0] occ, e_wr, e_clr;
        int  e_ei, cand, e_ii;
        bit  e_er, e_ef, e_iv, e_if;
        if (!reset_n) begin
            m_q.delete();
            m_lock = 1'b0;
            {s_flush, s_ef, s_if, s_lk} = '0;
            chk("rst_count", 32'(count), 0);
            chk("rst_issue_valid", 32'(issue_valid), 0);
            chk("rst_wr_en", 32'(entry_wr_en), 0);
            chk("rst_clear", 32'(entry_clear), 0);
            chk("rst_empty", 32'(empty), 1);
            chk("rst_full", 32'(full), 0);
        end else begin
            occ = '0;
            foreach (m_q[k]) occ[m_q[k]] = 1'b1;
            e_ei = 0;
            for (int i = DEPTH - 1; i >= 0; i--) if (!occ[i]) e_ei = i;
            e_er = !flush && (occ != 8'hFF);
            e_ef = enq_valid && e_er;
            e_wr = e_ef ? 8'(1 << e_ei) : 8'h00;
            cand = -1;
            foreach (m_q[k]) if (cand < 0 && entry_rdy[m_q[k]]) cand = m_q[k];
            e_iv = !flush && (m_lock || cand >= 0);
            e_ii = m_lock ? m_lidx : (cand < 0 ? 0 : cand);
            e_if = e_iv && issue_ready;
            e_clr = flush ? 8'hFF : (e_if ? 8'(1 << e_ii) : 8'h00);
            chk("enq_ready", 32'(enq_ready), 32'(e_er));
            if (occ != 8'hFF) chk("enq_idx", 32'(enq_idx), e_ei);
            chk("entry_wr_en", 32'(entry_wr_en), 32'(e_wr));
            chk("issue_valid", 32'(issue_valid), 32'(e_iv));
            if (e_iv) chk("issue_idx", 32'(issue_idx), e_ii);
            chk("entry_clear", 32'(entry_clear), 32'(e_clr));
            chk("count", 32'(count), m_q.size());
            chk("full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("valid_in_occ", 32'(entry_valid & ~occ), 0);
            s_flush = flush;
            s_ef = e_ef; s_ei = e_ei;
            s_if = e_if; s_ii = e_ii;
            s_lk = e_iv && !issue_ready;
        end
    end

    always @(posedge clock) begin
        if (reset_n) begin
            if (s_flush) begin
                m_q.delete();
                m_lock = 1'b0;
            end else begin
                if (s_if) begin
                    foreach (m_q[k]) if (m_q[k] == s_ii) begin m_q.delete(k); break; end
                    m_lock = 1'b0;
                end else if (s_lk) begin
                    m_lock = 1'b1;
                    m_lidx = s_ii;
                end
                if (s_ef) m_q.push_back(s_ei);
            end
            {s_flush, s_ef, s_if, s_lk} = '0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tick();
        @(negedge clock);
        chk("t0_empty", 32'(empty), 1);
        chk("t0_count", 32'(count), 0);
        tick();
        reset_n = 1'b1;

        // fill all eight slots back to back
        enq_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("t1_enq_idx", 32'(enq_idx), i);
            tick();
        end
        enq_valid = 1'b0;
        @(negedge clock);
        chk("t1_full", 32'(full), 1);
        chk("t1_enq_ready", 32'(enq_ready), 0);
        chk("t1_count", 32'(count), 8);
        tick();

        // issue slot 5 while full and enqueue pending
        want_rdy = 8'h20; issue_ready = 1'b1; enq_valid = 1'b1;
        @(negedge clock);
        chk("t4_issue_idx", 32'(issue_idx), 5);
        chk("t4_enq_ready", 32'(enq_ready), 0);
        chk("t4_clear", 32'(entry_clear), 32'h20);
        tick();
        want_rdy = '0; issue_ready = 1'b0;
        @(negedge clock);
        chk("t4_enq_idx", 32'(enq_idx), 5);
        chk("t4_count7", 32'(count), 7);
        tick();
        enq_valid = 1'b0;
        @(negedge clock);
        chk("t4_count8", 32'(count), 8);
        tick();

        // held offer on slot 2 while older slot 0 becomes ready
        want_rdy = 8'h04; issue_ready = 1'b0;
        @(negedge clock);
        chk("t3_offer", 32'(issue_idx), 2);
        tick();
        want_rdy = 8'h05;
        @(negedge clock);
        chk("t3_locked", 32'(issue_idx), 2);
        tick();
        issue_ready = 1'b1;
        @(negedge clock);
        chk("t3_accept", 32'(issue_idx), 2);
        chk("t3_clear2", 32'(entry_clear), 32'h04);
        tick();
        @(negedge clock);
        chk("t3_next", 32'(issue_idx), 0);
        chk("t3_clear0", 32'(entry_clear), 32'h01);
        tick();
        want_rdy = '0; issue_ready = 1'b0;
        @(negedge clock);
        chk("t3_count", 32'(count), 6);
        tick();

        // flush with a locked offer outstanding
        want_rdy = 8'h08;
        @(negedge clock);
        chk("t5_offer", 32'(issue_valid), 1);
        tick();
        flush = 1'b1;
        @(negedge clock);
        chk("t5_clear", 32'(entry_clear), 32'hFF);
        chk("t5_issue_valid", 32'(issue_valid), 0);
        chk("t5_enq_ready", 32'(enq_ready), 0);
        tick();
        flush = 1'b0; want_rdy = '0; enq_valid = 1'b1;
        @(negedge clock);
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_enq_idx", 32'(enq_idx), 0);
        tick();

        // fill 1..3 then both 1 and 3 ready: oldest first
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            chk("t2_enq_idx", 32'(enq_idx), i);
            tick();
        end
        enq_valid = 1'b0; want_rdy = 8'h0A; issue_ready = 1'b1;
        @(negedge clock);
        chk("t2_first", 32'(issue_idx), 1);
        chk("t2_clear1", 32'(entry_clear), 32'h02);
        tick();
        @(negedge clock);
        chk("t2_second", 32'(issue_idx), 3);
        chk("t2_clear3", 32'(entry_clear), 32'h08);
        tick();
        want_rdy = '0; issue_ready = 1'b0;

        // async reset in the middle of a refill
        enq_valid = 1'b1;
        @(negedge clock);
        chk("t6_enq_a", 32'(enq_idx), 1);
        tick();
        @(negedge clock);
        chk("t6_enq_b", 32'(enq_idx), 3);
        tick();
        enq_valid = 1'b0; want_rdy = 8'h01;
        @(negedge clock);
        chk("t6_pre_valid", 32'(issue_valid), 1);
        chk("t6_pre_count", 32'(count), 4);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_issue_valid", 32'(issue_valid), 0);
        chk("t6_rst_empty", 32'(empty), 1);
        want_rdy = '0;
        tick();
        reset_n = 1'b1; enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t6_refill", 32'(enq_idx), i);
            tick();
        end
        enq_valid = 1'b0;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
